// File: rtl/generation_sequencer.sv
// Generation sequencer: paces Game-of-Life style generations. Each generation
// sweeps every cell address to the cell engine over a valid/ready handshake,
// waits for the engine pipeline to drain, then swaps the front/back buffers.
module generation_sequencer #(
  parameter int unsigned GRID_W       = 80,
  parameter int unsigned GRID_H       = 60,
  parameter int unsigned XW           = 7,
  parameter int unsigned YW           = 6,
  parameter int unsigned PIPE_LATENCY = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          run,
  input  logic          step,
  input  logic          frame_tick,
  input  logic [7:0]    gen_period,
  output logic          cell_valid,
  input  logic          cell_ready,
  output logic [XW-1:0] cell_x,
  output logic [YW-1:0] cell_y,
  output logic          buf_sel,
  output logic [15:0]   gen_count,
  output logic          busy,
  output logic          gen_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StSwap  = 2'd3;

  localparam int unsigned DCW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [DCW-1:0] DrainLast = DCW'(PIPE_LATENCY - 1);
  localparam logic [XW-1:0]  XLast     = XW'(GRID_W - 1);
  localparam logic [YW-1:0]  YLast     = YW'(GRID_H - 1);

  logic [1:0]     state_q, state_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic [XW-1:0]  cell_x_q, cell_x_d;
  logic [YW-1:0]  cell_y_q, cell_y_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           buf_sel_q, buf_sel_d;
  logic [15:0]    gen_count_q, gen_count_d;

  logic [7:0] eff_period;
  logic [8:0] frame_next;
  logic       start;

  // Start condition: frame pacing while running, single-step otherwise.
  always_comb begin
    eff_period = (gen_period == 8'd0) ? 8'd1 : gen_period;
    // 9-bit sum so the comparison cannot wrap.
    frame_next = {1'b0, frame_cnt_q} + 9'd1;
    if (run) begin
      start = frame_tick && (frame_next >= {1'b0, eff_period});
    end else begin
      start = step;
    end
  end

  // Next-state logic for the FSM, address walker, drain timer and buffer swap.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    cell_x_d    = cell_x_q;
    cell_y_d    = cell_y_q;
    drain_cnt_d = drain_cnt_q;
    buf_sel_d   = buf_sel_q;
    gen_count_d = gen_count_q;
    case (state_q)
      StIdle: begin
        if (!run) begin
          frame_cnt_d = 8'd0;
        end else if (frame_tick) begin
          frame_cnt_d = frame_next[7:0];
        end
        if (start) begin
          state_d     = StSweep;
          frame_cnt_d = 8'd0;
        end
      end
      StSweep: begin
        if (cell_ready) begin
          if (cell_x_q == XLast) begin
            cell_x_d = '0;
            if (cell_y_q == YLast) begin
              cell_y_d    = '0;
              drain_cnt_d = '0;
              state_d     = StDrain;
            end else begin
              cell_y_d = cell_y_q + YW'(1);
            end
          end else begin
            cell_x_d = cell_x_q + XW'(1);
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          state_d = StSwap;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      StSwap: begin
        state_d     = StIdle;
        buf_sel_d   = ~buf_sel_q;
        gen_count_d = gen_count_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      frame_cnt_q <= 8'd0;
      cell_x_q    <= '0;
      cell_y_q    <= '0;
      drain_cnt_q <= '0;
      buf_sel_q   <= 1'b0;
      gen_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      drain_cnt_q <= drain_cnt_d;
      buf_sel_q   <= buf_sel_d;
      gen_count_q <= gen_count_d;
    end
  end

  // Outputs decode straight from state; the address registers are already 0 outside SWEEP.
  always_comb begin
    cell_valid = (state_q == StSweep);
    busy       = (state_q != StIdle);
    gen_done   = (state_q == StSwap);
    cell_x     = cell_x_q;
    cell_y     = cell_y_q;
    buf_sel    = buf_sel_q;
    gen_count  = gen_count_q;
  end

endmodule

// File: tb/tb_generation_sequencer.sv
// Bench for generation_sequencer on a 4x3 grid with a 4-cycle drain.
module tb_generation_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int L  = 4;
  localparam int NC = W * H;

  logic        clk = 1'b0;
  logic        resetn, run, step, frame_tick, cell_ready;
  logic [7:0]  gen_period;
  logic        cell_valid, buf_sel, busy, gen_done;
  logic [6:0]  cell_x;
  logic [5:0]  cell_y;
  logic [15:0] gen_count;

  always #5 clk = ~clk;

  generation_sequencer #(
    .GRID_W(W), .GRID_H(H), .XW(7), .YW(6), .PIPE_LATENCY(L)
  ) dut (
    .clk(clk), .resetn(resetn), .run(run), .step(step), .frame_tick(frame_tick),
    .gen_period(gen_period), .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_x(cell_x), .cell_y(cell_y), .buf_sel(buf_sel), .gen_count(gen_count),
    .busy(busy), .gen_done(gen_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a generation is a position through the cell list followed by
  // a tail count (1..L = drain, L+1 = swap).
  bit          m_in_gen;
  int          m_pos, m_tail, m_fc;
  bit          m_bsel;
  logic [15:0] m_gcnt;

  // obs = {valid, busy, done, bsel, x[6:0], y[5:0], gcnt[15:0]}
  logic [32:0] obs;
  bit          prev_busy;
  int          starts;

  typedef struct {
    logic       rn, r, s, t, rd;
    logic [7:0] gp;
    logic [32:0] exp;
  } vec_t;
  vec_t tab[22];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [32:0] model_exp();
    logic v, d;
    logic [6:0] x;
    logic [5:0] y;
    v = m_in_gen && (m_tail == 0);
    d = m_in_gen && (m_tail == L + 1);
    x = v ? 7'(m_pos % W) : 7'd0;
    y = v ? 6'(m_pos / W) : 6'd0;
    return {v, m_in_gen, d, m_bsel, x, y, m_gcnt};
  endfunction

  task automatic model_reset();
    m_in_gen = 0; m_pos = 0; m_tail = 0; m_fc = 0; m_bsel = 0; m_gcnt = 16'd0;
  endtask

  task automatic model_start();
    m_in_gen = 1; m_pos = 0; m_tail = 0; m_fc = 0;
  endtask

  task automatic model_step();
    int per;
    if (!resetn) begin
      model_reset();
    end else if (!m_in_gen) begin
      per = (gen_period == 0) ? 1 : int'(gen_period);
      if (run) begin
        if (frame_tick) begin
          if (m_fc + 1 >= per) model_start();
          else m_fc++;
        end
      end else begin
        m_fc = 0;
        if (step) model_start();
      end
    end else if (m_tail == 0) begin
      if (cell_ready) begin
        if (m_pos == NC - 1) m_tail = 1;
        else m_pos++;
      end
    end else if (m_tail <= L) begin
      m_tail++;
    end else begin
      m_in_gen = 0;
      m_bsel   = ~m_bsel;
      m_gcnt   = m_gcnt + 16'd1;
    end
  endtask

  task automatic set_in(input logic rn, input logic r, input logic s, input logic t,
                        input logic [7:0] gp, input logic rd);
    resetn = rn; run = r; step = s; frame_tick = t; gen_period = gp; cell_ready = rd;
  endtask

  // Called at a negedge with inputs driven; checks, then advances one clock.
  task automatic cyc(input bit use_tab, input logic [32:0] texp);
    #1;
    obs = {cell_valid, busy, gen_done, buf_sel, cell_x, cell_y, gen_count};
    check("model", obs, model_exp());
    if (use_tab) check("table", obs, texp);
    if (obs[31] && !prev_busy) starts++;
    prev_busy = obs[31];
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int held, at21, acc;
    logic [15:0] g0;

    // Single-step generation timeline, straight from the timing rules.
    for (int i = 0; i < 22; i++) begin
      tab[i] = '{rn: 1'b1, r: 1'b0, s: 1'b0, t: 1'b0, rd: 1'b1, gp: 8'd0, exp: 33'd0};
    end
    tab[0].s = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tab[i].exp = {1'b1, 1'b1, 1'b0, 1'b0, 7'((i - 1) % 4), 6'((i - 1) / 4), 16'd0};
    end
    for (int i = 13; i <= 16; i++) tab[i].exp = {1'b0, 1'b1, 31'd0};
    tab[17].exp = {1'b0, 1'b1, 1'b1, 30'd0};
    tab[18].exp = {4'b0001, 13'd0, 16'd1};
    tab[19] = '{rn: 1'b1, r: 1'b1, s: 1'b1, t: 1'b0, rd: 1'b1, gp: 8'd1,
                exp: {4'b0001, 13'd0, 16'd1}};
    tab[20].exp = {4'b0001, 13'd0, 16'd1};
    tab[21].exp = {4'b0001, 13'd0, 16'd1};

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    repeat (2) @(posedge clk);
    model_reset();
    prev_busy = 0;
    starts = 0;
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      set_in(tab[i].rn, tab[i].r, tab[i].s, tab[i].t, tab[i].gp, tab[i].rd);
      cyc(1'b1, tab[i].exp);
    end

    // Frame pacing: gen_period=3 then 0, a tick every 100 cycles.
    starts = 0;
    for (int c = 0; c < 900; c++) begin
      set_in(1'b1, 1'b1, 1'b0, (c % 100) == 50, 8'd3, 1'b1);
      cyc(1'b0, '0);
    end
    check_int("period3_starts", starts, 3);
    starts = 0;
    for (int c = 0; c < 500; c++) begin
      set_in(1'b1, 1'b1, 1'b0, (c % 100) == 50, 8'd0, 1'b1);
      cyc(1'b0, '0);
    end
    check_int("period0_starts", starts, 5);

    // Back-pressure on (2,1) for 5 cycles.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, '0);
    held = 0; at21 = 0; acc = 0;
    for (int c = 0; c < 40; c++) begin
      step = 1'b0;
      if (m_in_gen && m_tail == 0 && m_pos == 6 && held < 5) begin
        cell_ready = 1'b0; held++;
      end else begin
        cell_ready = 1'b1;
      end
      cyc(1'b0, '0);
      if (obs[32] && obs[28:22] == 7'd2 && obs[21:16] == 6'd1) at21++;
      if (obs[32] && cell_ready) acc++;
    end
    check_int("hold_21_cycles", at21, 6);
    check_int("accepted_addrs", acc, NC);

    // Steps with run=1 or during a generation start nothing extra.
    starts = 0;
    for (int c = 0; c < 30; c++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1);
      cyc(1'b0, '0);
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
    cyc(1'b0, '0);
    for (int c = 0; c < 30; c++) begin
      set_in(1'b1, 1'b0, (c < 16), 1'b0, 8'd1, 1'b1);
      cyc(1'b0, '0);
    end
    check_int("step_ignored_starts", starts, 1);

    // Run dropped mid-SWEEP: generation completes, then stays idle.
    g0 = m_gcnt;
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1);
    cyc(1'b0, '0);
    for (int c = 0; c < 40; c++) begin
      set_in(1'b1, (c < 3), 1'b0, 1'b0, 8'd0, 1'b1);
      cyc(1'b0, '0);
    end
    check("run_drop_gcnt", {17'd0, obs[15:0]}, {17'd0, g0 + 16'd1});
    check("run_drop_idle", {32'd0, obs[31]}, 33'd0);

    // Reset on the 7th accepted address abandons the generation.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, '0);
    step = 1'b0;
    for (int c = 0; c < 20 && !(m_in_gen && m_tail == 0 && m_pos == 6); c++) cyc(1'b0, '0);
    resetn = 1'b0;
    cyc(1'b0, '0);
    resetn = 1'b1;
    cyc(1'b0, '0);
    check("reset_outputs", obs, 33'd0);

    // gen_count wrap from 0xFFFF.
    force dut.gen_count_q = 16'hFFFF;
    #1;
    release dut.gen_count_q;
    m_gcnt = 16'hFFFF;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, '0);
    step = 1'b0;
    for (int c = 0; c < 25; c++) cyc(1'b0, '0);
    check("wrap_gcnt_bsel", {16'd0, obs[29], obs[15:0]}, {16'd0, 1'b1, 16'h0000});

    // Randomised traffic against the model.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      resetn     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 99) == 0) gen_period = 8'($urandom_range(0, 3));
      step       = ($urandom_range(0, 7) == 0);
      frame_tick = ($urandom_range(0, 5) == 0);
      cell_ready = ($urandom_range(0, 3) != 0);
      cyc(1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
